issue_sched: RTL and testbench

ISSUE_SCHED -- requirements
Module: issue_sched

---
 rtl/issue_sched.sv | 94 +++++++++
 tb/tb_issue_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/issue_sched.sv
// issue_sched: age-ordered issue queue with tag wakeup and oldest-ready selection.
// Defining ISSUE_SCHED_FLUSH_EN adds a flush input that clears the queue like rst.
module issue_sched #(
  parameter int DEPTH = 8,
  parameter int OP_W  = 7,
  parameter int TAG_W = 6,
  parameter int AGE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ISSUE_SCHED_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [OP_W-1:0]    disp_op,
  input  logic [TAG_W-1:0]   disp_tag,
  input  logic [TAG_W-1:0]   disp_src1,
  input  logic [TAG_W-1:0]   disp_src2,
  input  logic               disp_src1_rdy,
  input  logic               disp_src2_rdy,
  input  logic               wk_valid,
  input  logic [TAG_W-1:0]   wk_tag,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [OP_W-1:0]    iss_op,
  output logic [TAG_W-1:0]   iss_tag,
  output logic [TAG_W-1:0]   iss_src1,
  output logic [TAG_W-1:0]   iss_src2,
  output logic [AGE_W:0]     count,
  output logic               full,
  output logic               empty
);
  logic [DEPTH-1:0] valid, rdy1, rdy2, elig;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] src1_q [DEPTH];
  logic [TAG_W-1:0] src2_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [AGE_W-1:0] sel, free, new_age;
  logic             disp_fire, iss_fire, clr;
`ifdef ISSUE_SCHED_FLUSH_EN
  assign clr = rst | flush;
`else
  assign clr = rst;
`endif
  assign elig       = valid & rdy1 & rdy2;
  assign iss_valid  = |elig;
  assign iss_fire   = iss_valid && iss_ready;
  assign full       = count == (AGE_W+1)'(DEPTH);
  assign empty      = count == '0;
  assign disp_ready = !full;
  assign disp_fire  = disp_valid && disp_ready;
  // a freed slot is still valid this cycle, so it is never chosen as free
  assign new_age    = count[AGE_W-1:0] - AGE_W'(iss_fire);
  assign iss_op     = op_q[sel];
  assign iss_tag    = tag_q[sel];
  assign iss_src1   = src1_q[sel];
  assign iss_src2   = src2_q[sel];
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      if (elig[i] && (!elig[sel] || age_q[i] < age_q[sel])) sel = AGE_W'(i);
  end
  always_comb begin
    free = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid[i]) free = AGE_W'(i);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wk_valid && wk_tag == src1_q[i]) rdy1[i] <= 1'b1;
        if (wk_valid && wk_tag == src2_q[i]) rdy2[i] <= 1'b1;
        if (iss_fire && age_q[i] > age_q[sel]) age_q[i] <= age_q[i] - 1'b1;
      end
      if (iss_fire) valid[sel] <= 1'b0;
      if (disp_fire) begin
        valid[free]  <= 1'b1;
        op_q[free]   <= disp_op;
        tag_q[free]  <= disp_tag;
        src1_q[free] <= disp_src1;
        src2_q[free] <= disp_src2;
        rdy1[free]   <= disp_src1_rdy | (wk_valid && wk_tag == disp_src1);
        rdy2[free]   <= disp_src2_rdy | (wk_valid && wk_tag == disp_src2);
        age_q[free]  <= new_age;
      end
      count <= count + (AGE_W+1)'(disp_fire) - (AGE_W+1)'(iss_fire);
    end
  end
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: table-driven vectors plus directed sequences for full, ordering and reset corners.
module tb_issue_sched;
  logic       clk = 0, rst = 1;
  logic       disp_valid = 0, disp_ready, disp_src1_rdy = 0, disp_src2_rdy = 0;
  logic [6:0] disp_op = 0, iss_op;
  logic [5:0] disp_tag = 0, disp_src1 = 0, disp_src2 = 0, wk_tag = 0;
  logic [5:0] iss_tag, iss_src1, iss_src2;
  logic       wk_valid = 0, iss_valid, iss_ready = 0, full, empty;
  logic [3:0] count;
`ifdef ISSUE_SCHED_FLUSH_EN
  logic       flush = 0;
`endif
  int checks = 0, errors = 0;

  issue_sched dut (
    .clk(clk), .rst(rst),
`ifdef ISSUE_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag(disp_tag), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .wk_valid(wk_valid), .wk_tag(wk_tag), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_tag(iss_tag), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dv, tag, s1, r1, wv, wt, ir, ev, et, ec;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic cyc(input int dv, tag, s1, r1, s2, r2, wv, wt, ir);
    @(negedge clk);
    disp_valid = dv[0]; disp_tag = tag[5:0]; disp_op = {1'b1, tag[5:0]};
    disp_src1 = s1[5:0]; disp_src1_rdy = r1[0];
    disp_src2 = s2[5:0]; disp_src2_rdy = r2[0];
    wk_valid = wv[0]; wk_tag = wt[5:0]; iss_ready = ir[0];
    #1;
  endtask

  task automatic chk_state(input string n, input int ev, input int et, input int ec);
    chk({n, ".count"}, int'(count), ec);
    chk({n, ".full"}, int'(full), int'(ec == 8));
    chk({n, ".empty"}, int'(empty), int'(ec == 0));
    chk({n, ".disp_ready"}, int'(disp_ready), int'(ec != 8));
    chk({n, ".iss_valid"}, int'(iss_valid), ev);
    if (ev != 0) begin
      chk({n, ".iss_tag"}, int'(iss_tag), et);
      chk({n, ".iss_op"}, int'(iss_op), et + 64);
    end
  endtask

  task automatic add(input int dv, tag, s1, r1, wv, wt, ir, ev, et, ec);
    vq.push_back('{dv, tag, s1, r1, wv, wt, ir, ev, et, ec});
  endtask

  task automatic fill_reset_check(input string n, input bit use_flush);
    for (int k = 0; k < 5; k++) cyc(1, 1 + k, 0, 1, 63, 1, 0, 0, 0);
    cyc(1, 9, 0, 1, 63, 1, 0, 0, 1);
    chk_state({n, ".pre"}, 1, 1, 5);
`ifdef ISSUE_SCHED_FLUSH_EN
    if (use_flush) flush = 1; else rst = 1;
`else
    if (!use_flush) rst = 1;
`endif
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 0);
    rst = 0;
`ifdef ISSUE_SCHED_FLUSH_EN
    flush = 0;
`endif
    chk_state(n, 0, 0, 0);
  endtask

  initial begin
    int et[8];
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 0);
    rst = 0;
    // in-order issue of three ready entries
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 0, 0, 1, 1, 1);
    add(1, 3, 0, 1, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, 3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // younger ready entry bypasses older waiting one, then wakeup
    add(1, 10, 5, 0, 0, 0, 0, 0, 0, 0);
    add(1, 11, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 11, 2);
    add(0, 0, 0, 0, 1, 5, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 10, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // same-cycle wakeup at dispatch
    add(1, 12, 7, 0, 1, 7, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 12, 1);
    // simultaneous dispatch and issue
    add(1, 20, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 21, 0, 1, 0, 0, 1, 1, 20, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 21, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      cyc(vq[i].dv, vq[i].tag, vq[i].s1, vq[i].r1, 63, 1, vq[i].wv, vq[i].wt, vq[i].ir);
      chk_state($sformatf("vec%0d", i), vq[i].ev, vq[i].et, vq[i].ec);
    end
    // fill to full, overflow ignored, freed slot reused next cycle as youngest
    for (int k = 0; k < 8; k++) begin
      cyc(1, 30 + k, 0, 1, 63, 1, 0, 0, 0);
      chk($sformatf("fill%0d.count", k), int'(count), k);
    end
    cyc(1, 38, 0, 1, 63, 1, 0, 0, 0);
    chk_state("full", 1, 30, 8);
    cyc(1, 39, 0, 1, 63, 1, 0, 0, 1);
    chk_state("full.ovf", 1, 30, 8);
    cyc(1, 40, 0, 1, 63, 1, 0, 0, 0);
    chk_state("full.freed", 1, 31, 7);
    et = '{31, 32, 33, 34, 35, 36, 37, 40};
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 63, 1, 0, 0, 1);
      chk_state($sformatf("drain%0d", k), 1, et[k], 8 - k);
    end
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 0);
    chk_state("drained", 0, 0, 0);
    // hold with iss_ready low, then middle-age issue and contiguous ages
    cyc(1, 50, 0, 1, 63, 1, 0, 0, 0);
    cyc(1, 51, 0, 1, 60, 0, 0, 0, 0);
    cyc(1, 52, 0, 1, 63, 1, 0, 0, 0);
    cyc(1, 53, 0, 1, 63, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 63, 1, 0, 0, 0);
      chk_state($sformatf("hold%0d", k), 1, 50, 4);
    end
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 1);
    chk_state("mid.a", 1, 50, 4);
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 1);
    chk_state("mid.c", 1, 52, 3);
    cyc(0, 0, 0, 0, 63, 1, 1, 60, 0);
    chk_state("mid.d", 1, 53, 2);
    cyc(1, 54, 0, 1, 63, 1, 0, 0, 1);
    chk_state("mid.b", 1, 51, 2);
    chk("mid.b.src2", int'(iss_src2), 60);
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 1);
    chk_state("mid.d2", 1, 53, 2);
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 1);
    chk_state("mid.e", 1, 54, 1);
    cyc(0, 0, 0, 0, 63, 1, 0, 0, 0);
    chk_state("mid.done", 0, 0, 0);
    fill_reset_check("rst", 0);
`ifdef ISSUE_SCHED_FLUSH_EN
    fill_reset_check("flush", 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
